// File: rtl/periph_pkg.sv
// Shared peripheral definitions: UART register offsets and TX state encoding.
// Also intended for the receive side of the UART.
package periph_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Data-bus handshake between the core (master) and a peripheral (slave).
// Only the address/data bits a peripheral decodes are carried.
interface bus_if;

    logic        req;
    logic        we;
    logic [3:2]  addr;
    logic [15:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/periph_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head entry whenever empty is low.
// A pop frees its slot in the same cycle, so push is accepted when full if pop is also set.
module periph_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/periph_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register slave, TX FIFO, baud/bit counters and shifter.
// irq is a level interrupt raised when enabled and the transmitter has fully drained.
module periph_uart_tx
    import periph_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic clk,
    input  logic rst,
    bus_if.slave bus,
    output logic tx,
    output logic irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // bus side
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] div_q, div_d;
    logic        ie_q, ie_d;
    logic        irq_q, irq_d;
    logic        txw_req;
    logic        accept;

    // transmitter side
    uart_tx_state_t state_q, state_d;
    logic        tx_q, tx_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] fdiv_q, fdiv_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    // fifo
    logic          push;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count5;
    logic          busy;
    logic          push_eff;
    logic          empty_next;

    periph_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata_q[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign count5 = 5'(fifo_count);
    assign busy   = (state_q != IDLE);
    assign push   = wr_q & (waddr_q == UART_TXDATA);

    // The request is latched when accepted, so writes land on the edge ending the ready cycle.
    // A TXDATA write to a full FIFO is held off unless a pop frees a slot on this same edge.
    always_comb begin
        txw_req = bus.req & bus.we & (bus.addr == UART_TXDATA);
        accept  = bus.req & ~ready_q & (~txw_req | ~fifo_full | pop);
        ready_d = accept;
        wr_d    = accept & bus.we;
        waddr_d = accept ? bus.addr  : waddr_q;
        wdata_d = accept ? bus.wdata : wdata_q;
        rdata_d = '0;
        if (accept && !bus.we) begin
            unique case (bus.addr)
                UART_STATUS:  rdata_d = {23'd0, count5, irq_q, busy, fifo_empty, fifo_full};
                UART_DIVISOR: rdata_d = {16'd0, div_q};
                UART_CTRL:    rdata_d = {31'd0, ie_q};
                default:      rdata_d = '0;
            endcase
        end
        div_d = div_q;
        ie_d  = ie_q;
        if (wr_q && (waddr_q == UART_DIVISOR)) begin
            div_d = wdata_q;
        end
        if (wr_q && (waddr_q == UART_CTRL)) begin
            ie_d = wdata_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        baud_d  = baud_q;
        fdiv_d  = fdiv_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = fifo_rdata;
                    fdiv_d  = eff_div(div_q);
                    baud_d  = eff_div(div_q) - 16'd1;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = fdiv_q - 16'd1;
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = fdiv_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = fifo_rdata;
                        fdiv_d  = eff_div(div_q);
                        baud_d  = eff_div(div_q) - 16'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    // irq is registered from next-state values so it equals ie & empty & ~busy of the current state.
    always_comb begin
        push_eff   = push & (~fifo_full | pop);
        empty_next = fifo_empty ? ~push_eff
                                : ((fifo_count == CW'(1)) & pop & ~push_eff);
        irq_d      = ie_d & (state_d == IDLE) & empty_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            div_q   <= DIV_RESET;
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            fdiv_q  <= 16'd1;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            div_q   <= div_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
            state_q <= state_d;
            tx_q    <= tx_d;
            baud_q  <= baud_d;
            fdiv_q  <= fdiv_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign tx        = tx_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_periph_uart_tx.sv
// Bench for periph_uart_tx: register vector table, directed timing sequences, and random
// traffic checked by a line monitor against a queue of expected {byte, divisor} frames.
module tb_periph_uart_tx;
    import periph_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    logic irq;

    bus_if b();

    periph_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b),
        .tx  (tx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [31:0] exp;
    } vec_t;

    frame_t exp_q[$];
    int     mon_starts[$];
    bit     mon_busy = 1'b0;
    bit     mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One bus transaction; returns read data and the cycle in which ready was seen.
    task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [15:0] d,
                            output logic [31:0] rd, output int rcyc);
        int n;
        n = 0;
        rd = '0;
        rcyc = -1;
        b.req = 1'b1;
        b.we = w;
        b.addr = a;
        b.wdata = d;
        while (n < 500) begin
            @(negedge clk);
            if (b.ready === 1'b1) begin
                rd = b.rdata;
                rcyc = cyc;
                break;
            end
            n++;
        end
        b.req = 1'b0;
        b.we = 1'b0;
        if (rcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: no ready for addr %0d after %0d cycles", a, n);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames still pending", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_start(input int k);
        int n;
        n = 0;
        while (mon_starts.size() <= k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: frame %0d never began", k);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic int start_at(input int k);
        if (k < mon_starts.size()) return mon_starts[k];
        return -1000;
    endfunction

    // Line monitor: every sample of a frame must match {stop, data LSB first, start}, each bit div clocks long.
    initial begin
        frame_t     f;
        logic [9:0] bits;
        logic [7:0] got;
        logic       prev;
        int         bad;
        int         idx;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst && prev && tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                end else begin
                    f = exp_q.pop_front();
                    bits = {1'b1, f.data, 1'b0};
                    bad = 0;
                    got = '0;
                    for (int j = 0; j < 10 * f.div; j++) begin
                        if (j > 0) @(negedge clk);
                        idx = j / f.div;
                        if (tx !== bits[idx]) bad++;
                        if ((j % f.div) == (f.div / 2) && idx >= 1 && idx <= 8) got[idx-1] = tx;
                    end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame: got byte 0x%0h expected 0x%0h div %0d (%0d bad samples)",
                                 got, f.data, f.div, bad);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = tx;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[15];
        logic [31:0] rd;
        int          rc, rc2, c0, s, bad, d;
        int          rcy[10];
        int          lat[10];
        logic [7:0]  byt;

        b.req = 1'b0;
        b.we = 1'b0;
        b.addr = '0;
        b.wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, b.ready}, 32'd0);
        check("rst_rdata", b.rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Register vector table
        vt[0]  = '{1'b0, UART_STATUS,  16'h0000, 32'h0000_0002};
        vt[1]  = '{1'b0, UART_DIVISOR, 16'h0000, 32'd868};
        vt[2]  = '{1'b0, UART_CTRL,    16'h0000, 32'h0000_0000};
        vt[3]  = '{1'b0, UART_TXDATA,  16'h0000, 32'h0000_0000};
        vt[4]  = '{1'b1, UART_STATUS,  16'hFFFF, 32'h0000_0000};
        vt[5]  = '{1'b0, UART_STATUS,  16'h0000, 32'h0000_0002};
        vt[6]  = '{1'b1, UART_DIVISOR, 16'h1234, 32'h0000_0000};
        vt[7]  = '{1'b0, UART_DIVISOR, 16'h0000, 32'h0000_1234};
        vt[8]  = '{1'b1, UART_CTRL,    16'hFFFE, 32'h0000_0000};
        vt[9]  = '{1'b0, UART_CTRL,    16'h0000, 32'h0000_0000};
        vt[10] = '{1'b1, UART_CTRL,    16'h0001, 32'h0000_0000};
        vt[11] = '{1'b0, UART_CTRL,    16'h0000, 32'h0000_0001};
        vt[12] = '{1'b0, UART_STATUS,  16'h0000, 32'h0000_000A};
        vt[13] = '{1'b1, UART_CTRL,    16'h0000, 32'h0000_0000};
        vt[14] = '{1'b0, UART_STATUS,  16'h0000, 32'h0000_0002};
        for (int i = 0; i < 15; i++) begin
            bus_xfer(vt[i].we, vt[i].addr, vt[i].wdata, rd, rc);
            if (!vt[i].we) check($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // Reset mid-frame (monitor still disabled)
        bus_xfer(1'b1, UART_DIVISOR, 16'd4, rd, rc);
        bus_xfer(1'b1, UART_TXDATA, 16'h0000, rd, rc);
        wait_until(rc + 8);
        check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1 check("reset_async_tx", {31'd0, tx}, 32'd1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("reset_hold_tx_high", bad, 0);
        rst = 1'b1;
        bus_xfer(1'b0, UART_STATUS, 16'h0, rd, rc);
        check("post_reset_status", rd, 32'h2);
        bus_xfer(1'b0, UART_DIVISOR, 16'h0, rd, rc);
        check("post_reset_divisor", rd, 32'd868);
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // Single byte, DIVISOR=4
        bus_xfer(1'b1, UART_DIVISOR, 16'd4, rd, rc);
        mon_starts.delete();
        exp_q.push_back('{8'hA5, 4});
        bus_xfer(1'b1, UART_TXDATA, 16'h00A5, rd, rc);
        wait_until(rc + 10);
        bus_xfer(1'b0, UART_STATUS, 16'h0, rd, rc2);
        check("status_busy", rd, 32'h6);
        wait_done();
        check("tx_fall_latency", start_at(0) - rc, 2);
        bus_xfer(1'b0, UART_STATUS, 16'h0, rd, rc2);
        check("status_after_frame", rd, 32'h2);

        // Backpressure: 10 back-to-back writes at DIVISOR=2, the 10th finds the FIFO full
        bus_xfer(1'b1, UART_DIVISOR, 16'd2, rd, rc);
        mon_starts.delete();
        for (int k = 0; k < 10; k++) begin
            byt = 8'(8'h11 + 8'(k * 37));
            exp_q.push_back('{byt, 2});
            c0 = cyc;
            bus_xfer(1'b1, UART_TXDATA, {8'h00, byt}, rd, rc);
            rcy[k] = rc;
            lat[k] = rc - c0;
        end
        bad = 0;
        for (int k = 0; k < 9; k++) if (lat[k] > 2) bad++;
        check("no_early_stall", bad, 0);
        check("full_write_stalls", {31'd0, lat[9] > 2}, 32'd1);
        wait_done();
        check("stall_released_at_pop",
              {31'd0, (rcy[9] >= start_at(1)) && (rcy[9] <= start_at(1) + 1)}, 32'd1);
        check("frame_count_bp", mon_starts.size(), 10);
        bad = 0;
        for (int k = 1; k < 10; k++) if (start_at(k) - start_at(k-1) != 20) bad++;
        check("contiguous_frames", bad, 0);

        // Divisor change mid-frame
        bus_xfer(1'b1, UART_DIVISOR, 16'd4, rd, rc);
        mon_starts.delete();
        exp_q.push_back('{8'h00, 4});
        bus_xfer(1'b1, UART_TXDATA, 16'h0000, rd, rc);
        wait_start(0);
        s = start_at(0);
        wait_until(s + 16);
        exp_q.push_back('{8'h55, 8});
        bus_xfer(1'b1, UART_DIVISOR, 16'd8, rd, rc);
        bus_xfer(1'b1, UART_TXDATA, 16'h0055, rd, rc);
        wait_done();
        check("div_change_gap", start_at(1) - s, 40);

        // IRQ
        bus_xfer(1'b1, UART_DIVISOR, 16'd4, rd, rc);
        bus_xfer(1'b1, UART_CTRL, 16'h0001, rd, rc);
        wait_until(rc + 2);
        check("irq_idle_enabled", {31'd0, irq}, 32'd1);
        mon_starts.delete();
        exp_q.push_back('{8'h3C, 4});
        bus_xfer(1'b1, UART_TXDATA, 16'h003C, rd, rc);
        wait_until(rc + 2);
        check("irq_drop_after_push", {31'd0, irq}, 32'd0);
        wait_start(0);
        s = start_at(0);
        wait_until(s + 20);
        check("irq_mid_frame", {31'd0, irq}, 32'd0);
        wait_until(s + 39);
        check("irq_during_stop", {31'd0, irq}, 32'd0);
        wait_until(s + 40);
        check("irq_after_stop", {31'd0, irq}, 32'd1);
        wait_done();
        bus_xfer(1'b0, UART_STATUS, 16'h0, rd, rc);
        check("status_irq_bit", rd, 32'hA);
        bus_xfer(1'b1, UART_CTRL, 16'h0000, rd, rc);
        wait_until(rc + 2);
        check("irq_disabled", {31'd0, irq}, 32'd0);

        // DIVISOR=0 behaves as one clock per bit
        bus_xfer(1'b1, UART_DIVISOR, 16'd0, rd, rc);
        bus_xfer(1'b0, UART_DIVISOR, 16'h0, rd, rc);
        check("divisor_zero_readback", rd, 32'd0);
        mon_starts.delete();
        exp_q.push_back('{8'h96, 1});
        bus_xfer(1'b1, UART_TXDATA, 16'h0096, rd, rc);
        wait_done();
        check("div0_frame_seen", mon_starts.size(), 1);

        // Random traffic; the divisor only changes once the line has drained
        d = 3;
        bus_xfer(1'b1, UART_DIVISOR, 16'(d), rd, rc);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                wait_done();
                d = int'($urandom_range(0, 5));
                bus_xfer(1'b1, UART_DIVISOR, 16'(d), rd, rc);
            end
            byt = 8'($urandom);
            exp_q.push_back('{byt, (d == 0) ? 1 : d});
            bus_xfer(1'b1, UART_TXDATA, {8'h00, byt}, rd, rc);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_done();
        check("all_frames_sent", exp_q.size(), 0);
        bus_xfer(1'b0, UART_STATUS, 16'h0, rd, rc);
        check("final_status", rd, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
